// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 selector family: select-mode encodings
// and a wrapped first-set search used by the round-robin picker.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Largest channel count supported by the shared search helper.
    localparam int MAX_N  = 16;
    localparam int MAX_IW = 4;

    // Returns {found, index} of the first set bit of req[n-1:0], scanning
    // upward from position 'start' and wrapping past n-1 back to 0.
    // The loop runs from the farthest offset down so the nearest hit wins.
    function automatic logic [MAX_IW:0] first_set_wrap(
        input logic [MAX_N-1:0] req,
        input int               start,
        input int               n
    );
        logic [MAX_IW:0] res;
        int              p;
        res = '0;
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                p = start + k;
                if (p >= n) begin
                    p = p - n;
                end
                if (req[p[MAX_IW-1:0]]) begin
                    res = {1'b1, p[MAX_IW-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_nx1_arb_rr_pick.sv
// Rotate-priority encoder: finds the first requesting channel strictly after
// the pointer, wrapping around. Purely combinational so other arbiters can
// reuse it with their own pointer registers.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [MAX_N-1:0]  req_ext;
    logic [MAX_IW:0]   res;
    int                start;

    // Start one past the pointer (mod N) and take the first requester found.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        start          = (int'(ptr) >= N - 1) ? 0 : int'(ptr) + 1;
        res            = first_set_wrap(req_ext, start, N);
        idx            = res[IW-1:0];
        found          = res[MAX_IW];
    end

endmodule

// File: rtl/mux_nx1_arb.sv
// N-input, WIDTH-bit selector with per-channel valid/ready, a registered
// output stage and two select modes (fixed index or round-robin).
// Legal N_INPUTS range is 2..16; SEL_W is derived and should not be set.
module mux_nx1_arb
    import mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_INPUTS = 8,
    parameter int SEL_W    = $clog2(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic                      sel_load,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]       in_valid,
    output logic [N_INPUTS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_sel_reg;
    logic             out_valid_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] rr_ptr;

    logic [WIDTH-1:0] ch_data [N_INPUTS];
    logic             slot_free;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             sel_in_ok;

    // Unpack the flat data bus into one word per channel.
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // The output register can take a new word if empty or being drained now.
    assign slot_free = !out_valid_reg || out_ready;
    assign sel_in_ok = int'(sel_in) < N_INPUTS;

    rr_pick #(
        .N  (N_INPUTS),
        .IW (SEL_W)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Grant decision; ready is forced low while reset is held.
    always_comb begin
        gnt_idx   = sel_reg;
        gnt_valid = 1'b0;
        if (mode == MODE_RR) begin
            gnt_idx   = rr_idx;
            gnt_valid = rr_found && slot_free;
        end else begin
            gnt_valid = in_valid[sel_reg] && slot_free;
        end
        in_ready = '0;
        if (gnt_valid && rst_n) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output stage: capture on transfer, drop valid when drained and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else if (gnt_valid) begin
            out_data_reg  <= ch_data[gnt_idx];
            out_sel_reg   <= gnt_idx;
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Select register and round-robin pointer. The pointer starts at the
    // last channel so channel 0 is first in line, and survives mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg <= '0;
            rr_ptr  <= SEL_W'(N_INPUTS - 1);
        end else begin
            if (sel_load && sel_in_ok) begin
                sel_reg <= sel_in;
            end
            if (gnt_valid && mode == MODE_RR) begin
                rr_ptr <= gnt_idx;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Bench for mux_nx1_arb: directed scenarios plus a randomized run, all
// checked against a queue-free behavioural model of the grant rules.
module tb_mux_nx1_arb;

    localparam int N = 8;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           mode;
    logic           sel_load;
    logic [2:0]     sel_in;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_valid;
    logic           out_ready;

    // Second instance with a non-power-of-two channel count, so that
    // out-of-range select indices can actually be driven.
    logic           b_mode;
    logic           b_sel_load;
    logic [2:0]     b_sel_in;
    logic [47:0]    b_in_data;
    logic [5:0]     b_in_valid;
    logic [5:0]     b_in_ready;
    logic [7:0]     b_out_data;
    logic [2:0]     b_out_sel;
    logic           b_out_valid;
    logic           b_out_ready;

    logic [W-1:0]   ch [N];

    int tests_run;
    int tests_failed;

    // Model state
    logic           m_valid;
    logic [W-1:0]   m_data;
    int             m_sel;
    int             m_selreg;
    int             m_ptr;

    mux_nx1_arb #(.WIDTH(W), .N_INPUTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel_load  (sel_load),
        .sel_in    (sel_in),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_nx1_arb #(.WIDTH(8), .N_INPUTS(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (b_mode),
        .sel_load  (b_sel_load),
        .sel_in    (b_sel_in),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_sel    = 0;
        m_selreg = 0;
        m_ptr    = N - 1;
    endtask

    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        if (mode == 1'b0) return in_valid[m_selreg] ? m_selreg : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + 1 + k) % N;
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (g >= 0) begin
            m_data  = ch[g];
            m_sel   = g;
            m_valid = 1'b1;
            if (mode == 1'b1) m_ptr = g;
            $display("[TB] xfer ch=%0d data=%08h mode=%0d", g, ch[g], mode);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (sel_load && int'(sel_in) < N) m_selreg = int'(sel_in);
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = ch[i];
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) ch[i] = $urandom;
        pack();
    endtask

    // Advance one clock edge, update the model, settle outputs.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        sel_load  = 1'b0;
        sel_in    = '0;
        randomize_data();
        model_reset();
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_out: valid=%0b data=%08h sel=%0d required 0/0/0",
                     out_valid, out_data, out_sel);
        end
        tests_run++;
        if (in_ready !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ready: in_ready=%02h required 00", in_ready);
        end
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
    endtask

    task automatic test_first_word();
        @(negedge clk);
        mode      = 1'b0;
        ch[0]     = 32'hDEAD_BEEF;
        pack();
        in_valid  = 8'h01;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 8'h01) begin
            tests_failed++;
            $display("FAIL first_ready: in_ready=%02h required 01", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_sel !== 3'd0) begin
            tests_failed++;
            $display("FAIL first_word: valid=%0b data=%08h sel=%0d required 1/deadbeef/0",
                     out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_fixed_sel();
        logic [W-1:0] exp_d;
        @(negedge clk);
        in_valid = '0;
        sel_load = 1'b1;
        sel_in   = 3'd5;
        #1;
        tests_run++;
        if (in_ready !== 8'h00) begin
            tests_failed++;
            $display("FAIL fixed_idle_ready: in_ready=%02h required 00", in_ready);
        end
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sel_load = 1'b0;
            in_valid = 8'hFF;
            randomize_data();
            exp_d = ch[5];
            #1;
            tests_run++;
            if (in_ready !== 8'h20) begin
                tests_failed++;
                $display("FAIL fixed_ready[%0d]: in_ready=%02h required 20", k, in_ready);
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_sel !== 3'd5 || out_data !== exp_d) begin
                tests_failed++;
                $display("FAIL fixed_word[%0d]: valid=%0b sel=%0d data=%08h required 1/5/%08h",
                         k, out_valid, out_sel, out_data, exp_d);
            end
        end
        // Load concurrent with a transfer: this word still uses channel 5.
        @(negedge clk);
        sel_load = 1'b1;
        sel_in   = 3'd2;
        randomize_data();
        exp_d = ch[5];
        tick();
        tests_run++;
        if (out_sel !== 3'd5 || out_data !== exp_d) begin
            tests_failed++;
            $display("FAIL fixed_load_concurrent: sel=%0d data=%08h required 5/%08h",
                     out_sel, out_data, exp_d);
        end
        @(negedge clk);
        sel_load = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 8'h04) begin
            tests_failed++;
            $display("FAIL fixed_new_sel: in_ready=%02h required 04", in_ready);
        end
        tick();
    endtask

    task automatic test_sel_ignore();
        logic [2:0] loads [5];
        int         exp_sel;
        loads[0] = 3'd3;
        loads[1] = 3'd7;
        loads[2] = 3'd6;
        loads[3] = 3'd5;
        loads[4] = 3'd0;
        exp_sel  = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            b_sel_load = 1'b1;
            b_sel_in   = loads[k];
            if (int'(loads[k]) < 6) exp_sel = int'(loads[k]);
            @(negedge clk);
            b_sel_load = 1'b0;
            #1;
            tests_run++;
            if (b_in_ready !== 6'(1 << exp_sel)) begin
                tests_failed++;
                $display("FAIL sel_ignore[%0d]: in_ready=%02h required %02h",
                         k, b_in_ready, 6'(1 << exp_sel));
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (b_out_sel !== 3'(exp_sel) || b_out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL sel_ignore_out[%0d]: sel=%0d valid=%0b required %0d/1",
                         k, b_out_sel, b_out_valid, exp_sel);
            end
        end
    endtask

    task automatic test_rr_fair();
        logic [W-1:0] exp_d;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k != 0) @(negedge clk);
            mode      = 1'b1;
            in_valid  = 8'hFF;
            out_ready = 1'b1;
            randomize_data();
            exp_d = ch[k % N];
            #1;
            tests_run++;
            if (in_ready !== 8'(1 << (k % N))) begin
                tests_failed++;
                $display("FAIL rr_fair_ready[%0d]: in_ready=%02h required %02h",
                         k, in_ready, 8'(1 << (k % N)));
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_sel !== 3'(k % N) || out_data !== exp_d) begin
                tests_failed++;
                $display("FAIL rr_fair_word[%0d]: valid=%0b sel=%0d data=%08h required 1/%0d/%08h",
                         k, out_valid, out_sel, out_data, k % N, exp_d);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int seq [4];
        seq[0] = 0;
        seq[1] = 2;
        seq[2] = 6;
        seq[3] = 0;
        // Park the pointer on channel 6.
        @(negedge clk);
        in_valid = 8'h40;
        tick();
        tests_run++;
        if (out_sel !== 3'd6) begin
            tests_failed++;
            $display("FAIL rr_park: sel=%0d required 6", out_sel);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 8'b0100_0101;
            randomize_data();
            #1;
            tests_run++;
            if (in_ready !== 8'(1 << seq[k])) begin
                tests_failed++;
                $display("FAIL rr_sparse_ready[%0d]: in_ready=%02h required %02h",
                         k, in_ready, 8'(1 << seq[k]));
            end
            tick();
            tests_run++;
            if (out_sel !== 3'(seq[k])) begin
                tests_failed++;
                $display("FAIL rr_sparse_sel[%0d]: sel=%0d required %0d", k, out_sel, seq[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_d;
        logic [2:0]   held_s;
        logic [W-1:0] exp_d;
        int           g;
        @(negedge clk);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        randomize_data();
        tick();
        held_d = m_data;
        held_s = 3'(m_sel);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            randomize_data();
            #1;
            tests_run++;
            if (in_ready !== 8'h00) begin
                tests_failed++;
                $display("FAIL stall_ready[%0d]: in_ready=%02h required 00", k, in_ready);
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_sel !== held_s) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: valid=%0b data=%08h sel=%0d required 1/%08h/%0d",
                         k, out_valid, out_data, out_sel, held_d, held_s);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        randomize_data();
        #1;
        g = model_grant();
        exp_d = (g >= 0) ? ch[g] : '0;
        tests_run++;
        if (in_ready !== exp_ready() || in_ready === 8'h00) begin
            tests_failed++;
            $display("FAIL passthru_ready: in_ready=%02h required %02h", in_ready, exp_ready());
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== 3'(g)) begin
            tests_failed++;
            $display("FAIL passthru_word: valid=%0b data=%08h sel=%0d required 1/%08h/%0d",
                     out_valid, out_data, out_sel, exp_d, g);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%0b in_ready=%02h required 0/00", out_valid, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 8'b0011_0100;
        out_ready = 1'b1;
        randomize_data();
        #1;
        tests_run++;
        if (in_ready !== 8'h04) begin
            tests_failed++;
            $display("FAIL post_reset_ready: in_ready=%02h required 04", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_sel !== 3'd2) begin
            tests_failed++;
            $display("FAIL post_reset_word: valid=%0b sel=%0d required 1/2", out_valid, out_sel);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            mode      = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            sel_load  = ($urandom_range(0, 3) == 0);
            sel_in    = 3'($urandom_range(0, 7));
            randomize_data();
            #1;
            tests_run++;
            if (in_ready !== exp_ready()) begin
                tests_failed++;
                $display("FAIL rand_ready[%0d]: in_ready=%02h required %02h", k, in_ready, exp_ready());
            end
            tick();
            tests_run++;
            if (out_valid !== m_valid || out_data !== m_data || out_sel !== 3'(m_sel)) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: valid=%0b data=%08h sel=%0d required %0b/%08h/%0d",
                         k, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
            end
        end
        @(negedge clk);
        sel_load = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        b_mode       = 1'b0;
        b_sel_load   = 1'b0;
        b_sel_in     = '0;
        b_in_data    = 48'h3C3C_5A5A_A5A5;
        b_in_valid   = 6'h3F;
        b_out_ready  = 1'b1;
        test_reset();
        test_first_word();
        test_fixed_sel();
        test_sel_ignore();
        test_rr_fair();
        test_rr_sparse();
        test_backpressure();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
